hilo_muldiv_unit: RTL and testbench

- Next-generation HI/LO block for the MIPS CPU: parametrised HI/LO register pair with an integrated iterative multiply/divide engine.
- Executes MULT/MULTU/DIV/DIVU over WIDTH cycles and writes the 2*WIDTH result into HI/LO.
- Keeps direct MTHI/MTLO write ports and exposes busy/done so the pipeline can stall MFHI/MFLO until results land.

---
 rtl/hilo_pkg.sv | 36 +++
 rtl/hilo_iter_core.sv | 81 ++++++++
 rtl/hilo_muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the divide-by-zero quotient pattern.
package hilo_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'b000,
    OpMultu = 3'b001,
    OpDiv   = 3'b010,
    OpDivu  = 3'b011,
    OpMadd  = 3'b100,
    OpMaddu = 3'b101,
    OpMsub  = 3'b110,
    OpMsubu = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFin
  } state_e;

  // Widest data path supported; DivZeroLo is sliced down to WIDTH.
  localparam int MaxWidth = 64;
  localparam logic [MaxWidth-1:0] DivZeroLo = {MaxWidth{1'b1}};

  // Only 010/011 divide; 110/111 are multiply-subtract.
  function automatic logic op_is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Combinational datapath for the HI/LO engine: operand magnitudes, one shift-add
// or restoring-divide step per call, and the final sign correction.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg_a,
  output logic             o_neg_b,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_p_hi,
  input  logic [WIDTH-1:0] i_p_lo,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_step_hi,
  output logic [WIDTH-1:0] o_step_lo,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  input  logic             i_div0,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo
);

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_diff;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes; unsigned ops pass through untouched.
  always_comb begin
    o_neg_a = i_signed & i_a[WIDTH-1];
    o_neg_b = i_signed & i_b[WIDTH-1];
    o_mag_a = o_neg_a ? -i_a : i_a;
    o_mag_b = o_neg_b ? -i_b : i_b;
  end

  // Multiply: add multiplicand when LSB of multiplier set, shift {hi,lo} right.
  assign w_sum = {1'b0, i_p_hi} + (i_p_lo[0] ? {1'b0, i_d} : {(WIDTH+1){1'b0}});

  // Divide: shift next dividend bit into remainder, subtract if it fits.
  // Without a borrow the true difference is below i_d, so the low WIDTH bits suffice.
  assign w_rem_sh = {i_p_hi, i_p_lo[WIDTH-1]};
  assign w_borrow = (w_rem_sh < {1'b0, i_d});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - i_d;

  // Select the step result for the active operation.
  always_comb begin
    if (i_is_div) begin
      o_step_hi = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff;
      o_step_lo = {i_p_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      o_step_hi = w_sum[WIDTH:1];
      o_step_lo = {w_sum[0], i_p_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished product or quotient/remainder.
  // Divide-by-zero forces an all-ones quotient; the remainder already equals a.
  always_comb begin
    w_prod     = {i_p_hi, i_p_lo};
    w_prod_fix = i_neg_q ? -w_prod : w_prod;
    w_quo      = i_div0 ? DivZeroLo[WIDTH-1:0] : (i_neg_q ? -i_p_lo : i_p_lo);
    w_rem      = i_neg_r ? -i_p_hi : i_p_hi;
    if (i_is_div) begin
      o_res_hi = w_rem;
      o_res_lo = w_quo;
    end else begin
      o_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      o_res_lo = w_prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative multiply/divide engine. One iteration per
// cycle, WIDTH+2 cycles from start to done. Optional multiply-accumulate ops
// (MADD/MADDU/MSUB/MSUBU) are built when HILO_MADD_EN is defined.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_d;
  logic             r_op_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_op_ok;
  logic             w_accept;
  logic             w_last;
  logic             w_iter;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

`ifdef HILO_MADD_EN
  logic               r_op_acc;
  logic               r_op_sub;
  logic [2*WIDTH-1:0] w_acc_cur;
  logic [2*WIDTH-1:0] w_acc_new;

  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~op[2];
`endif

  assign w_accept = start & (r_state == StIdle) & w_op_ok;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_iter   = (r_state == StMul) | (r_state == StDiv);

  hilo_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a      (a),
    .i_b      (b),
    .i_signed (op_is_signed(op)),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_a  (w_neg_a),
    .o_neg_b  (w_neg_b),
    .i_is_div (r_op_div),
    .i_p_hi   (r_p_hi),
    .i_p_lo   (r_p_lo),
    .i_d      (r_d),
    .o_step_hi(w_step_hi),
    .o_step_lo(w_step_lo),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_div0   (r_div0),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> MUL/DIV on accepted start, iterate, FIN writes back.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = op_is_div(op) ? StDiv : StMul;
      end
      StMul, StDiv: begin
        if (w_last) w_state_next = StFin;
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Iteration counter: runs only in MUL/DIV, zero otherwise.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)      r_cnt <= '0;
    else if (w_iter) r_cnt <= r_cnt + CNT_W'(1);
    else             r_cnt <= '0;
  end

  // Working registers: load magnitudes and sign flags at start, step while iterating.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_p_hi   <= '0;
      r_p_lo   <= '0;
      r_d      <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      r_p_hi   <= '0;
      r_p_lo   <= w_mag_a;
      r_d      <= w_mag_b;
      r_op_div <= op_is_div(op);
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      r_div0   <= (b == '0);
    end else if (w_iter) begin
      r_p_hi   <= w_step_hi;
      r_p_lo   <= w_step_lo;
    end
  end

`ifdef HILO_MADD_EN
  // Accumulate-op flags, captured alongside the operands.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_op_acc <= 1'b0;
      r_op_sub <= 1'b0;
    end else if (w_accept) begin
      r_op_acc <= op[2];
      r_op_sub <= op[1];
    end
  end

  // Accumulate the signed/unsigned product into {HI,LO}, wrapping modulo 2^(2*WIDTH).
  always_comb begin
    w_acc_cur = {r_hi, r_lo};
    w_acc_new = r_op_sub ? (w_acc_cur - {w_res_hi, w_res_lo})
                         : (w_acc_cur + {w_res_hi, w_res_lo});
    if (r_op_acc) begin
      w_fin_hi = w_acc_new[2*WIDTH-1:WIDTH];
      w_fin_lo = w_acc_new[WIDTH-1:0];
    end else begin
      w_fin_hi = w_res_hi;
      w_fin_lo = w_res_lo;
    end
  end
`else
  assign w_fin_hi = w_res_hi;
  assign w_fin_lo = w_res_lo;
`endif

  // HI/LO: result lands at the FIN edge; MTHI/MTLO only while idle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == StFin) begin
      r_hi <= w_fin_hi;
      r_lo <= w_fin_lo;
    end else if (r_state == StIdle) begin
      if (we_hi) r_hi <= hi_in;
      if (we_lo) r_lo <= lo_in;
    end
  end

  // Done pulse for the cycle following the write-back edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_done <= 1'b0;
    else        r_done <= (r_state == StFin);
  end

  assign busy   = (r_state != StIdle);
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (WIDTH=32). Covers the
// HILO_MADD_EN build when that macro is defined, the rejection of 1xx ops otherwise.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .hi_in (hi_in),
    .lo_in (lo_in),
    .busy  (busy),
    .done  (done),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Launch one op; cycle i is sampled at the i-th negedge after the start edge.
  // At cycle inj_cyc a competing start plus MTHI/MTLO are driven for one cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inj_cyc, input logic wr_start,
                       output int busy_cyc, output int done_cyc, output logic [31:0] hi_c1);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    we_hi = wr_start; hi_in = 32'h0000BEEF;
    @(posedge clk);
    #1;
    start = 1'b0; we_hi = 1'b0;
    busy_cyc = 0; done_cyc = 0; hi_c1 = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      if (i == 1) hi_c1 = hi_out;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = i;
        break;
      end
      if (i == inj_cyc) begin
        start = 1'b1; op = OpMultu; a = 32'd3; b = 32'd3;
        we_hi = 1'b1; hi_in = 32'h00005555;
        we_lo = 1'b1; lo_in = 32'h0000AAAA;
      end
    end
  endtask

  initial begin
    int          bc;
    int          dc;
    int          cnt_busy;
    int          cnt_done;
    logic [31:0] h1;

    clr_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    we_hi = 1'b0; we_lo = 1'b0; hi_in = '0; lo_in = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi_out), 64'h0);
    check("rst_lo", 64'(lo_out), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    clr_n = 1'b1;

    do_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, bc, dc, h1);
    check("multu_hi", 64'(hi_out), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo_out), 64'h00000001);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_done_cycle", 64'(dc), 64'd34);

    do_op(OpMult, 32'hFFFFFFFD, 32'd7, 0, 1'b0, bc, dc, h1);
    check("mult_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo_out), 64'hFFFFFFEB);

    do_op(OpDiv, 32'hFFFFFFF9, 32'd2, 0, 1'b0, bc, dc, h1);
    check("div_lo", 64'(lo_out), 64'hFFFFFFFD);
    check("div_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("div_done_cycle", 64'(dc), 64'd34);

    // MTHI together with start: visible after E0, then overwritten by the result.
    do_op(OpDivu, 32'd7, 32'd0, 0, 1'b1, bc, dc, h1);
    check("start_mthi_c1", 64'(h1), 64'h0000BEEF);
    check("divu0_hi", 64'(hi_out), 64'h00000007);
    check("divu0_lo", 64'(lo_out), 64'hFFFFFFFF);

    do_op(OpDiv, 32'hFFFFFFF9, 32'd0, 0, 1'b0, bc, dc, h1);
    check("div0s_hi", 64'(hi_out), 64'hFFFFFFF9);
    check("div0s_lo", 64'(lo_out), 64'hFFFFFFFF);

    do_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, bc, dc, h1);
    check("divmin_lo", 64'(lo_out), 64'h80000000);
    check("divmin_hi", 64'(hi_out), 64'h0);

    // Competing start and MTHI/MTLO mid-operation are dropped.
    do_op(OpDiv, 32'd100, 32'd7, 5, 1'b0, bc, dc, h1);
    check("busy_ign_lo", 64'(lo_out), 64'd14);
    check("busy_ign_hi", 64'(hi_out), 64'd2);
    check("busy_ign_done", 64'(dc), 64'd34);

    // Same at the FIN edge; the start must not be queued either.
    do_op(OpDivu, 32'd1003, 32'd10, 33, 1'b0, bc, dc, h1);
    check("fin_ign_lo", 64'(lo_out), 64'd100);
    check("fin_ign_hi", 64'(hi_out), 64'd3);
    @(negedge clk);
    check("fin_no_queue", 64'(busy), 64'h0);

    // Asynchronous clear mid-multiply.
    @(negedge clk);
    op = OpMultu; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("abort_hi", 64'(hi_out), 64'h0);
    check("abort_lo", 64'(lo_out), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    @(negedge clk);
    clr_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("abort_no_done", 64'(cnt_done), 64'h0);
    we_hi = 1'b1; hi_in = 32'h00001234;
    @(posedge clk);
    #1;
    we_hi = 1'b0;
    check("mthi_after_clr", 64'(hi_out), 64'h00001234);

`ifdef HILO_MADD_EN
    @(negedge clk);
    we_hi = 1'b1; hi_in = 32'h0; we_lo = 1'b1; lo_in = 32'd5;
    @(posedge clk);
    #1;
    we_hi = 1'b0; we_lo = 1'b0;
    do_op(OpMadd, 32'd2, 32'd3, 0, 1'b0, bc, dc, h1);
    check("madd_lo", 64'(lo_out), 64'h0000000B);
    check("madd_hi", 64'(hi_out), 64'h0);
    check("madd_done_cycle", 64'(dc), 64'd34);
    do_op(OpMsubu, 32'd1, 32'h0000000C, 0, 1'b0, bc, dc, h1);
    check("msubu_hi", 64'(hi_out), 64'hFFFFFFFF);
    check("msubu_lo", 64'(lo_out), 64'hFFFFFFFF);
`else
    @(negedge clk);
    op = OpMadd; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt_busy = 0; cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cnt_busy++;
      if (done) cnt_done++;
    end
    check("madd_off_busy", 64'(cnt_busy), 64'h0);
    check("madd_off_done", 64'(cnt_done), 64'h0);
    check("madd_off_hi", 64'(hi_out), 64'h00001234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
